// File: rtl/ucsbece154a_mem_responder_pkg.sv
// rtl/ucsbece154a_mem_responder_pkg.sv - shared encodings and constants for the memory responder
package ucsbece154a_mem_responder_pkg;

  // Responder FSM encodings, kept next to the other controller state encodings.
  typedef enum logic [1:0] {
    resp_state_Idle = 2'b00,
    resp_state_Wait = 2'b01,
    resp_state_Resp = 2'b10
  } resp_state_e;

  localparam int MEM_WORD_BYTES = 4;
  localparam int MEM_OFF_W      = $clog2(MEM_WORD_BYTES);
  localparam int MEM_WORD_W     = 32;
  localparam int CNT_W          = 4;

endpackage

// File: rtl/ucsbece154a_mem_array.sv
// rtl/ucsbece154a_mem_array.sv - word array with synchronous write and combinational read
module ucsbece154a_mem_array
  import ucsbece154a_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [MEM_WORD_W-1:0] wd,
  output logic [MEM_WORD_W-1:0] rd
);

  // Contents survive reset on purpose; only the responder FSM is reset.
  logic [MEM_WORD_W-1:0] mem [DEPTH_WORDS];

  // Single write port, committed on the rising edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wd;
    end
  end

  assign rd = mem[idx];

endmodule

// File: rtl/ucsbece154a_mem_responder.sv
// rtl/ucsbece154a_mem_responder.sv - single-outstanding memory responder with emulated latency
module ucsbece154a_mem_responder
  import ucsbece154a_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  input  logic                  req_write_i,
  input  logic [31:0]           req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  req_ready_o,
  output logic                  resp_valid_o,
  output logic [MEM_WORD_W-1:0] resp_rdata_o,
  output logic                  resp_err_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  resp_state_e             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    wr_q, wr_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [MEM_OFF_W-1:0]    off_q, off_d;
  logic [MEM_WORD_W-1:0]   wdata_q, wdata_d;

  logic                    aligned;
  logic                    arr_we;
  logic [MEM_WORD_W-1:0]   arr_rd;

  // Address bits above the array span are ignored so addresses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr_i[31:IDX_W+MEM_OFF_W];

  assign aligned = (off_q == '0);
  // Writes are driven only from latched state in RESP, so an X on req_valid_i cannot reach the array.
  assign arr_we  = (state_q == resp_state_Resp) && wr_q && aligned;

  ucsbece154a_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk (clk),
    .we  (arr_we),
    .idx (idx_q),
    .wd  (wdata_q),
    .rd  (arr_rd)
  );

  // State, wait counter and latched request; reset aborts any in-flight access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= resp_state_Idle;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      off_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state, request capture and response outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    idx_d        = idx_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    resp_rdata_o = '0;
    resp_err_o   = 1'b0;

    case (state_q)
      resp_state_Idle: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          wr_d    = req_write_i;
          idx_d   = req_addr_i[IDX_W+MEM_OFF_W-1:MEM_OFF_W];
          off_d   = req_addr_i[MEM_OFF_W-1:0];
          wdata_d = req_wdata_i;
          cnt_d   = LAT_M1;
          state_d = (LATENCY == 1) ? resp_state_Resp : resp_state_Wait;
        end
      end
      resp_state_Wait: begin
        cnt_d = cnt_q - 1'b1;
        // A zero count here is unreachable but must not strand the FSM.
        if (cnt_q <= 1) begin
          cnt_d   = '0;
          state_d = resp_state_Resp;
        end
      end
      resp_state_Resp: begin
        resp_valid_o = 1'b1;
        resp_err_o   = !aligned;
        if (!wr_q && aligned) begin
          resp_rdata_o = arr_rd;
        end
        state_d = resp_state_Idle;
      end
      default: begin
        state_d = resp_state_Idle;
      end
    endcase
  end

endmodule

// File: tb/tb_ucsbece154a_mem_responder.sv
// tb/tb_ucsbece154a_mem_responder.sv - directed table-driven bench for the memory responder
module tb_ucsbece154a_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        vld  [3];
  logic        wr   [3];
  logic [31:0] addr [3];
  logic [31:0] wd   [3];
  logic        rdy  [3];
  logic        rv   [3];
  logic [31:0] rd   [3];
  logic        er   [3];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: LATENCY=2, instance 1: LATENCY=1, instance 2: LATENCY=15.
  ucsbece154a_mem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(rst_n),
    .req_valid_i(vld[0]), .req_write_i(wr[0]), .req_addr_i(addr[0]), .req_wdata_i(wd[0]),
    .req_ready_o(rdy[0]), .resp_valid_o(rv[0]), .resp_rdata_o(rd[0]), .resp_err_o(er[0]));

  ucsbece154a_mem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(rst_n),
    .req_valid_i(vld[1]), .req_write_i(wr[1]), .req_addr_i(addr[1]), .req_wdata_i(wd[1]),
    .req_ready_o(rdy[1]), .resp_valid_o(rv[1]), .resp_rdata_o(rd[1]), .resp_err_o(er[1]));

  ucsbece154a_mem_responder #(.DEPTH_WORDS(64), .LATENCY(15)) u_l15 (
    .clk(clk), .reset(rst_n),
    .req_valid_i(vld[2]), .req_write_i(wr[2]), .req_addr_i(addr[2]), .req_wdata_i(wd[2]),
    .req_ready_o(rdy[2]), .resp_valid_o(rv[2]), .resp_rdata_o(rd[2]), .resp_err_o(er[2]));

  typedef struct {
    int          k;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [$];

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 15;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Issue one request, wait for its response and check latency, data and error flag.
  task automatic do_req(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err);
    int n;
    int lat;
    @(negedge clk);
    vld[k] = 1'b1; wr[k] = w; addr[k] = a; wd[k] = d;
    n = 0;
    while (!rdy[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("accept_ready_k%0d_a%h", k, a), 32'(rdy[k]), 32'd1);
    @(negedge clk);
    vld[k] = 1'b0;
    check($sformatf("ready_drop_k%0d_a%h", k, a), 32'(rdy[k]), 32'd0);
    lat = 1;
    while (!rv[k] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("latency_k%0d_a%h", k, a), 32'(lat), 32'(lat_of(k)));
    check($sformatf("resp_valid_k%0d_a%h", k, a), 32'(rv[k]), 32'd1);
    check($sformatf("rdata_k%0d_a%h", k, a), rd[k], exp_rd);
    check($sformatf("err_k%0d_a%h", k, a), 32'(er[k]), 32'(exp_err));
    @(negedge clk);
    check($sformatf("pulse_end_k%0d_a%h", k, a), 32'(rv[k]), 32'd0);
    check($sformatf("rdata_idle_k%0d_a%h", k, a), rd[k], 32'd0);
  endtask

  initial begin
    int pulses;
    int pulse_off;
    int bad_ready;
    logic [31:0] cap_rd;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wd[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_ready_%0d", i), 32'(rdy[i]), 32'd1);
      check($sformatf("reset_valid_%0d", i), 32'(rv[i]), 32'd0);
      check($sformatf("reset_rdata_%0d", i), rd[i], 32'd0);
      check($sformatf("reset_err_%0d", i), 32'(er[i]), 32'd0);
    end
    rst_n = 1'b1;

    // Write/read pairs, wrap-around, misalignment and preloads.
    vecs.push_back('{0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0});
    vecs.push_back('{0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0});
    vecs.push_back('{0, 1'b1, 32'h100, 32'h12345678, 32'h0,        1'b0});
    vecs.push_back('{0, 1'b0, 32'h0,   32'h0,        32'h12345678, 1'b0});
    vecs.push_back('{0, 1'b1, 32'h20,  32'h0BADF00D, 32'h0,        1'b0});
    vecs.push_back('{0, 1'b1, 32'h22,  32'hFFFFFFFF, 32'h0,        1'b1});
    vecs.push_back('{0, 1'b0, 32'h20,  32'h0,        32'h0BADF00D, 1'b0});
    vecs.push_back('{0, 1'b0, 32'h23,  32'h0,        32'h0,        1'b1});
    vecs.push_back('{0, 1'b1, 32'h8,   32'h5A5A0001, 32'h0,        1'b0});
    vecs.push_back('{1, 1'b1, 32'h0,   32'h11111111, 32'h0,        1'b0});
    vecs.push_back('{1, 1'b1, 32'h4,   32'h22222222, 32'h0,        1'b0});
    vecs.push_back('{2, 1'b1, 32'h40,  32'hCAFE0015, 32'h0,        1'b0});
    vecs.push_back('{2, 1'b1, 32'h44,  32'h00000044, 32'h0,        1'b0});

    foreach (vecs[i]) begin
      do_req(vecs[i].k, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp_rd, vecs[i].exp_err);
    end

    // LATENCY=1 back-to-back reads with valid held high.
    @(negedge clk);
    vld[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h0;
    check("b2b_ready0", 32'(rdy[1]), 32'd1);
    @(negedge clk);
    check("b2b_resp0", 32'(rv[1]), 32'd1);
    check("b2b_rdata0", rd[1], 32'h11111111);
    check("b2b_busy0", 32'(rdy[1]), 32'd0);
    addr[1] = 32'h4;
    @(negedge clk);
    check("b2b_ready1", 32'(rdy[1]), 32'd1);
    check("b2b_gap", 32'(rv[1]), 32'd0);
    @(negedge clk);
    vld[1] = 1'b0;
    check("b2b_resp1", 32'(rv[1]), 32'd1);
    check("b2b_rdata1", rd[1], 32'h22222222);
    @(negedge clk);
    check("b2b_idle", 32'(rdy[1]), 32'd1);

    // Reset one cycle after accepting a write: aborted, array untouched.
    @(negedge clk);
    vld[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h8; wd[0] = 32'hAAAA5555;
    check("rst_pre_ready", 32'(rdy[0]), 32'd1);
    @(negedge clk);
    vld[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_async_ready", 32'(rdy[0]), 32'd1);
    check("rst_async_valid", 32'(rv[0]), 32'd0);
    @(negedge clk);
    check("rst_no_pulse", 32'(rv[0]), 32'd0);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rv[0]) pulses++;
    end
    check("rst_no_late_pulse", 32'(pulses), 32'd0);
    do_req(0, 1'b0, 32'h8, 32'h0, 32'h5A5A0001, 1'b0);

    // LATENCY=15 read with valid toggling (as a write to 0x44) during WAIT.
    @(negedge clk);
    vld[2] = 1'b1; wr[2] = 1'b0; addr[2] = 32'h40; wd[2] = 32'h0;
    check("l15_ready", 32'(rdy[2]), 32'd1);
    pulses = 0; pulse_off = -1; bad_ready = 0; cap_rd = '0;
    for (int off = 1; off <= 20; off++) begin
      @(negedge clk);
      if (off <= 13) begin
        vld[2] = off[0]; wr[2] = 1'b1; addr[2] = 32'h44; wd[2] = 32'hFFFF0000;
      end else begin
        vld[2] = 1'b0;
      end
      if (off <= 15 && rdy[2]) bad_ready++;
      if (rv[2]) begin
        pulses++;
        pulse_off = off;
        cap_rd = rd[2];
      end
    end
    check("l15_pulses", 32'(pulses), 32'd1);
    check("l15_pulse_offset", 32'(pulse_off), 32'd15);
    check("l15_rdata", cap_rd, 32'hCAFE0015);
    check("l15_ready_low", 32'(bad_ready), 32'd0);
    do_req(2, 1'b0, 32'h44, 32'h0, 32'h00000044, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
